// File: rtl/float_mul_pipe_ctrl.sv
// Flow-control sequencer for the pipelined FP multiplier: per-stage load enables with
// bubble collapsing, destination-register tracking and RAW hazard detection for decode.
module float_mul_pipe_ctrl #(
  parameter int DEPTH = 3,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    in_fd,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [RW-1:0]    out_fd,
  output logic [DEPTH-1:0] stage_en,
  output logic [DEPTH-1:0] stage_valid,
  input  logic [RW-1:0]    fs,
  input  logic [RW-1:0]    ft,
  input  logic             use_fs,
  input  logic             use_ft,
  output logic             raw_hazard,
  output logic             busy,
  output logic [2:0]       occupancy
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [RW-1:0]    d_q [DEPTH];
  logic [RW-1:0]    d_d [DEPTH];
  logic [DEPTH-1:0] en;
  logic             raw;
  logic [2:0]       occ;

  // A stage may load if it is empty or everything downstream of it will move.
  always_comb begin : enable_chain
    logic room;
    room            = out_ready | ~v_q[DEPTH-1];
    en              = '0;
    en[DEPTH-1]     = room;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      room  = ~v_q[i] | room;
      en[i] = room;
    end
  end

  // Flush clears valids only; destinations are left stale since nothing reads them unqualified.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (en[0]) begin
        v_d[0] = in_valid & en[0];
        d_d[0] = in_fd;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (en[i]) begin
          v_d[i] = v_q[i-1];
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    raw = 1'b0;
    occ = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i]) begin
        occ = occ + 3'd1;
        if ((use_fs && d_q[i] == fs) || (use_ft && d_q[i] == ft)) raw = 1'b1;
      end
    end
  end

  assign stage_en    = en;
  assign in_ready    = en[0];
  assign stage_valid = v_q;
  assign out_valid   = v_q[DEPTH-1];
  assign out_fd      = d_q[DEPTH-1];
  assign raw_hazard  = raw;
  assign occupancy   = occ;
  assign busy        = (occ != 3'd0);

endmodule

// File: tb/tb_float_mul_pipe_ctrl.sv
// Scoreboard bench for float_mul_pipe_ctrl: an op-list reference model predicts the
// per-cycle outputs, and a monitor checks every retirement against the issue queue.
module tb_float_mul_pipe_ctrl;
  localparam int D  = 3;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready, use_fs, use_ft;
  logic [RW-1:0] in_fd, fs, ft;
  logic          in_ready, out_valid, raw_hazard, busy;
  logic [RW-1:0] out_fd;
  logic [D-1:0]  stage_en, stage_valid;
  logic [2:0]    occupancy;

  float_mul_pipe_ctrl #(.DEPTH(D), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fd(in_fd), .out_ready(out_ready), .out_valid(out_valid), .out_fd(out_fd),
    .stage_en(stage_en), .stage_valid(stage_valid), .fs(fs), .ft(ft),
    .use_fs(use_fs), .use_ft(use_ft), .raw_hazard(raw_hazard), .busy(busy),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            pos;
    logic [RW-1:0] fd;
  } op_t;

  op_t           ops[$];   // in-flight ops, oldest first, with their stage position
  logic [RW-1:0] sb[$];    // destinations expected to retire, in order
  int            checks   = 0;
  int            failures = 0;
  bit            started  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ops slide forward one stage per cycle but never onto an older op.
  always @(posedge clk) begin
    int  lim, np;
    bit  ir;
    op_t t;
    if (!rst_n) begin
      ops.delete();
      sb.delete();
      started = 1'b1;
    end else if (flush) begin
      ops.delete();
      sb.delete();
    end else begin
      ir = (ops.size() < D) || out_ready;
      if (ops.size() > 0 && ops[0].pos == D - 1 && out_ready) void'(ops.pop_front());
      lim = D;
      for (int k = 0; k < ops.size(); k++) begin
        np = ops[k].pos + 1;
        if (np > lim - 1) np = lim - 1;
        t = ops[k];
        t.pos = np;
        ops[k] = t;
        lim = np;
      end
      if (in_valid && ir) begin
        t.pos = 0;
        t.fd  = in_fd;
        ops.push_back(t);
        sb.push_back(in_fd);
      end
    end
  end

  // Monitor: compare combinational outputs against the model and pop on every retirement.
  always @(negedge clk) begin
    logic [D-1:0]  e_sv, e_en;
    logic [RW-1:0] e_fd;
    bit            e_raw;
    int            n;
    if (started) begin
      e_sv  = '0;
      e_raw = 1'b0;
      foreach (ops[k]) begin
        e_sv[ops[k].pos] = 1'b1;
        if ((use_fs && ops[k].fd == fs) || (use_ft && ops[k].fd == ft)) e_raw = 1'b1;
      end
      for (int i = 0; i < D; i++) begin
        n = 0;
        foreach (ops[k]) if (ops[k].pos >= i) n++;
        e_en[i] = out_ready || (n < D - i);
      end
      check("occupancy", int'(occupancy), ops.size());
      check("busy", int'(busy), int'(ops.size() != 0));
      check("stage_valid", int'(stage_valid), int'(e_sv));
      check("out_valid", int'(out_valid), int'(e_sv[D-1]));
      check("in_ready", int'(in_ready), int'((ops.size() < D) || out_ready));
      check("stage_en", int'(stage_en), int'(e_en));
      check("raw_hazard", int'(raw_hazard), int'(e_raw));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("retire_unexpected", int'(out_fd), -1);
        end else begin
          e_fd = sb.pop_front();
          check("out_fd", int'(out_fd), int'(e_fd));
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [RW-1:0] fd);
    in_valid = 1'b1;
    in_fd    = fd;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_fd = 5'd3; out_ready = 1'b0;
    fs = '0; ft = '0; use_fs = 1'b0; use_ft = 1'b0;
    cyc(2);
    check("reset_out_fd", int'(out_fd), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1; in_valid = 1'b0;
    cyc(2);

    // Streaming
    out_ready = 1'b1;
    for (int f = 1; f <= 4; f++) issue(RW'(f));
    cyc(6);

    // Backpressure and bubble collapse
    out_ready = 1'b0;
    issue(5'd5);
    cyc();
    issue(5'd6);
    cyc(4);
    issue(5'd7);
    cyc(2);
    out_ready = 1'b1;
    cyc(5);

    // Hazard tracking
    out_ready = 1'b0;
    issue(5'd9);
    fs = 5'd9; use_fs = 1'b1; cyc();
    use_fs = 1'b0; cyc();
    ft = 5'd9; use_ft = 1'b1; cyc();
    out_ready = 1'b1; cyc(4);
    use_ft = 1'b0;

    // Flush with a full pipe and a same-cycle issue
    out_ready = 1'b0;
    issue(5'd20); issue(5'd21); issue(5'd22);
    in_valid = 1'b1; in_fd = 5'd23; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(6);

    // Retire and issue together while full
    out_ready = 1'b0;
    issue(5'd10); issue(5'd11); issue(5'd13);
    out_ready = 1'b1;
    issue(5'd12);
    cyc(5);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_fd     = RW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      fs        = RW'($urandom_range(0, 7));
      ft        = RW'($urandom_range(0, 7));
      use_fs    = $urandom_range(0, 1) == 1;
      use_ft    = $urandom_range(0, 1) == 1;
      rst_n     = ($urandom_range(0, 999) != 0);
      cyc();
    end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cyc();
      guard++;
    end
    check("drain_remaining", sb.size(), 0);
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/float_mul_pipe_ctrl.md
Name: float_mul_pipe_ctrl

Overview:
Sequencing controller for the pipelined single-precision float multiplier.
- Generates the per-stage register enables (the `en` inputs of the inter-stage registers, e.g. the m->a register) using valid/ready flow control with bubble collapsing.
- Tracks the destination FP register held in each stage and flags RAW hazards against issuing instructions.
- Sits between the FPU issue logic and the multiplier datapath registers.

Parameters:
- DEPTH, 3, number of pipeline register stages controlled (index 0 = first register after issue, DEPTH-1 = result register); legal range 2..6.
- RW, 5, width of FP register specifier.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  issue logic presents a multiply.
- in_ready  output  1  controller accepts issue this cycle.
- in_fd  input  RW  destination register of issued multiply.
- out_ready  input  1  writeback accepts result.
- out_valid  output  1  result register holds a valid result.
- out_fd  output  RW  destination of result in last stage.
- stage_en  output  DEPTH  load enable for stage register i.
- stage_valid  output  DEPTH  valid bit per stage.
- fs, ft  input  RW  source specifiers of instruction in decode.
- use_fs, use_ft  input  1  corresponding source is read.
- raw_hazard  output  1  decode must stall.
- busy  output  1  any stage valid.
- occupancy  output  3  number of valid stages (0..DEPTH).

Behaviour:
- Reset (rst_n=0 at posedge): all v[i]=0 and all d[i]=0. Outputs then read out_valid=0, busy=0, occupancy=0, raw_hazard=0, out_fd=0, in_ready=1, stage_en all 1. Reset mid-operation discards every in-flight op; there is no partial drain.
- Enables, combinational:
  - stage_en[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - stage_en[i] = !v[i] | stage_en[i+1] for i<DEPTH-1.
  - in_ready = stage_en[0].
  - A bubble anywhere lets upstream stages advance while downstream is stalled.
- Valid/dest update per posedge, when stage_en[i]=1:
  - v[0] <= in_valid & in_ready; d[0] <= in_fd.
  - v[i] <= v[i-1]; d[i] <= d[i-1].
  - When stage_en[i]=0, stage i holds.
- Output: out_valid = v[DEPTH-1]; out_fd = d[DEPTH-1]. A result retires when out_valid & out_ready. A retirement and a new issue in the same cycle are both legal.
- Latency: an issue at cycle T with no stalls gives out_valid at T+DEPTH. Throughput is 1 per cycle.
- flush has priority over issue and stalls: at the next posedge all v[i]=0 and d[i] are left unchanged. in_valid in the same cycle is dropped (in_ready still reads as computed; the issuer must not count it).
- raw_hazard = OR over i of v[i] & ((use_fs & d[i]==fs) | (use_ft & d[i]==ft)).
  - Purely combinational on the current state.
  - Does not include the op being issued in the same cycle; the issue logic serialises that case.
- occupancy = popcount(v); busy = (occupancy != 0).
- Full pipeline with out_ready=0: all stage_en=0 and in_ready=0. in_valid is ignored and state holds indefinitely.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, occupancy=0, in_ready=1, stage_en=3'b111; 2 cycles after release with in_valid=0, still idle.
- Streaming: issue fd=1,2,3,4 back-to-back with out_ready=1 → out_valid rises at T+3; out_fd sequence is 1,2,3,4 on consecutive cycles; occupancy peaks at 3.
- Backpressure/bubble collapse: issue fd=5, one idle cycle, then fd=6, with out_ready=0 from the first out_valid → both stages close up; occupancy=2, v=3'b110, in_ready=1; a third issue fd=7 gives occupancy=3, in_ready=0. Raising out_ready drains 5,6,7 in order.
- Hazard: fd=9 in stage 1; fs=9 with use_fs=1 → raw_hazard=1; use_fs=0 → 0; ft=9 with use_ft=1 → 1. Once fd=9 retires → 0.
- Flush: with 3 valid ops and in_valid=1, assert flush for 1 cycle → next cycle occupancy=0, out_valid=0, no result ever appears for the flushed or same-cycle issue.
- Simultaneous retire+issue when full: out_ready=1, in_valid=1 with fd=12 → in_ready=1; occupancy stays 3 and fd=12 exits 3 cycles later.
